// File: rtl/cla_nibble_sequencer.sv
// -----------------------------------------------------------------------------
// cla_nibble_sequencer
//
// Multi-word addition controller wrapped around an external 4-bit
// carry-lookahead adder stage. One operand pair (plus carry-in) is accepted
// over a valid/ready handshake. The pair is then fed to the CLA one nibble per
// cycle, least-significant nibble first. Each nibble's carry-out is chained into
// the next nibble's carry-in. The assembled sum and the final carry are
// presented on a valid/ready output and held under backpressure.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous, active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  block can accept an operand beat (IDLE only)
//   in_a       in   operand A, 4*NIBBLES bits
//   in_b       in   operand B, 4*NIBBLES bits
//   in_cin     in   carry into bit 0
//   cla_a      out  current nibble of A to the CLA stage (0 outside RUN)
//   cla_b      out  current nibble of B to the CLA stage (0 outside RUN)
//   cla_cin    out  carry to the CLA stage (0 outside RUN)
//   cla_s      in   CLA sum nibble, combinational response to cla_*
//   cla_cout   in   CLA carry-out
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts result
//   out_sum    out  assembled sum, registered
//   out_cout   out  carry out of bit W-1, registered
//   busy       out  high in RUN and DONE
// -----------------------------------------------------------------------------
module cla_nibble_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic                   in_cin,
  output logic [3:0]             cla_a,
  output logic [3:0]             cla_b,
  output logic                   cla_cin,
  input  logic [3:0]             cla_s,
  input  logic                   cla_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_sum,
  output logic                   out_cout,
  output logic                   busy
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IDXW = $clog2(NIBBLES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q,   state_d;
  logic [IDXW-1:0] idx_q,     idx_d;
  logic [W-1:0]    a_q,       a_d;
  logic [W-1:0]    b_q,       b_d;
  logic            carry_q,   carry_d;
  logic [W-1:0]    sum_q,     sum_d;
  logic [W-1:0]    out_sum_q, out_sum_d;
  logic            out_cout_q, out_cout_d;

  // Nibble base bit offset: idx*4 without a multiplier.
  logic [IDXW+1:0] nib_base;
  assign nib_base = {idx_q, 2'b00};

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    sum_d      = sum_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    cla_a      = 4'd0;
    cla_b      = 4'd0;
    cla_cin    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Held low while reset is asserted so no beat looks accepted.
        in_ready = rst_n;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        cla_a   = a_q[nib_base +: 4];
        cla_b   = b_q[nib_base +: 4];
        cla_cin = carry_q;
        sum_d[nib_base +: 4] = cla_s;
        carry_d = cla_cout;
        if (idx_q == LAST_IDX) begin
          // Publish the whole result at once so out_sum never shows a
          // half-assembled value while the next operation is running.
          out_sum_d  = sum_d;
          out_cout_d = cla_cout;
          state_d    = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      sum_q      <= '0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      sum_q      <= sum_d;
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
    end
  end

  assign out_sum  = out_sum_q;
  assign out_cout = out_cout_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cla_nibble_sequencer
//
// Bench for cla_nibble_sequencer with NIBBLES=4. A behavioural 4-bit adder
// stands in for the external CLA stage. The driver pushes the expected
// {cout,sum} into a scoreboard queue at each accepted operand beat. A separate
// monitor pops and compares at every output handshake. Directed timing checks
// cover latency, carry ripple, backpressure and asynchronous reset. They are
// followed by a randomized regression with random output stalls.
// -----------------------------------------------------------------------------
module tb_cla_nibble_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic [3:0]   cla_a;
  logic [3:0]   cla_b;
  logic         cla_cin;
  logic [3:0]   cla_s;
  logic         cla_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  cla_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .cla_a     (cla_a),
    .cla_b     (cla_b),
    .cla_cin   (cla_cin),
    .cla_s     (cla_s),
    .cla_cout  (cla_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  // External CLA stage model: purely combinational 4-bit add.
  assign {cla_cout, cla_s} = {1'b0, cla_a} + {1'b0, cla_b} + {4'd0, cla_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int overlap_cnt = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random stalls, 2: never ready
  logic [W:0] sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // out_ready driver, updated mid-cycle after the driver's own updates.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compare at every output handshake; watch in_ready/busy overlap.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && in_ready) overlap_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          logic [W:0] e;
          e = sb.pop_front();
          check("result", {47'd0, out_cout, out_sum}, {47'd0, e});
        end
      end
    end
  end

  // Called at posedge+1; returns at acceptance edge +1.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int k;
    logic [W:0] e;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 500) begin
      @(posedge clk); #1; k++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    @(posedge clk);
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((!in_ready || sb.size() != 0) && k < 500) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 500) check("idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int k;
    logic [W-1:0] held_sum;
    logic         held_cout;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_out_sum",   64'(out_sum),   64'd0);
    check("rst_out_cout",  64'(out_cout),  64'd0);
    check("rst_cla",       64'({cla_a, cla_b, cla_cin}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);

    // 0x1234 + 0x4321: latency and single-cycle out_valid.
    send(16'h1234, 16'h4321, 1'b0);
    check("busy_after_accept", 64'(busy), 64'd1);
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("latency_edges", 64'(k + 1), 64'(N + 1));
    @(posedge clk); #1;
    check("out_valid_one_cycle", 64'(out_valid), 64'd0);
    check("in_ready_after_hs",   64'(in_ready),  64'd1);
    check("busy_after_hs",       64'(busy),      64'd0);
    wait_idle();

    // 0xFFFF + 0x0001: carry must ripple into every upper nibble.
    send(16'hFFFF, 16'h0001, 1'b0);
    for (int i = 0; i < N; i++) begin
      check("ripple_cla_cin", 64'(cla_cin), (i == 0) ? 64'd0 : 64'd1);
      @(posedge clk); #1;
    end
    check("cla_idle_after_run", 64'({cla_a, cla_b, cla_cin}), 64'd0);
    wait_idle();

    send(16'hFFFF, 16'h0000, 1'b1);
    wait_idle();
    send(16'h8000, 16'h8000, 1'b0);
    wait_idle();

    // Backpressure: 0x5050 + 0x5555 = 0xA5A5 held for 10 cycles.
    rdy_mode = 2;
    send(16'h5050, 16'h5555, 1'b0);
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk); #1; k++;
    end
    held_sum  = out_sum;
    held_cout = out_cout;
    check("bp_sum_value", 64'({held_cout, held_sum}), 64'h0A5A5);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i % 2);
      in_a = 16'h0F0F + 16'(i);
      in_b = 16'h1111;
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_sum_stable", 64'({out_cout, out_sum}), 64'({held_cout, held_sum}));
      check("bp_in_ready",  64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    @(posedge clk); #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    wait_idle();

    // Asynchronous reset in the middle of nibble 2.
    send(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",      64'(busy),      64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_cla",       64'({cla_a, cla_b, cla_cin}), 64'd0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0001, 16'h0001, 1'b0);
    wait_idle();
    check("post_rst_sum", 64'({out_cout, out_sum}), 64'h00002);

    // Randomized regression with random output stalls.
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      send(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
           1'($urandom_range(0, 1)));
    end
    k = 0;
    while (sb.size() != 0 && k < 500) begin
      @(posedge clk); #1; k++;
    end
    rdy_mode = 0;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    check("in_ready_busy_overlap", 64'(overlap_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
